decode_stage: RTL and testbench

Instruction decode stage plus ID/EX pipeline register for the 8-opcode, 9-bit-instruction CPU. It takes the IF/ID instruction, drives register-file read addresses and latches operands. It produces the `ControlSignals` bundle and registered `ForwardSel` selects that the execute stage consumes. It also detects load-use hazards (stalls IF, inserts a bubble) and applies branch flushes.

---
 rtl/decode_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Instruction decode and ID/EX pipeline register for the 8-opcode CPU with
// 9-bit instructions. The IF/ID instruction is split into opcode/rd/rt. The
// rd/rt fields go straight out as register-file read addresses, and the read
// data comes back in the same cycle. Decoded control, operands, register
// addresses and forwarding selects are registered into ID/EX. A load-use
// hazard produces a one-cycle stall with a bubble. A branch flush turns the
// decoding slot into a bubble.
//
// Parameters
//   INSTR_W     instruction width (opcode in the top 3 bits)
//   REG_ADDR_W  register address width
//   DATA_W      register data width
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_valid, if_instr             IF/ID slot: {opcode, rd, rt}
//   rf_raddr_a, rf_raddr_b         register-file read addresses (rd, rt)
//   rf_rdata_a, rf_rdata_b         register-file read data (write-first RF)
//   flush                          branch taken in EX: drop the decoding slot
//   ex_mem_regwrite, ex_mem_rd     EX/MEM producer, used for forwarding
//   stall_out                      load-use stall; IF and IF/ID hold
//   id_ex_valid, id_ex_ctrl        ID/EX slot valid and ControlSignals
//   id_ex_a, id_ex_b               latched operands (rd value, rt value)
//   id_ex_rd, id_ex_rt             latched register addresses
//   id_ex_fwd_a, id_ex_fwd_b       registered ForwardSel per operand
//   stall_count                    load-use bubble counter
//
// Configuration
//   DECODE_STALL_CNT_EN  when defined, stall_count counts stall cycles and
//                        saturates at 16'hFFFF. When undefined, it is tied
//                        to 0.
//
// Flow control: this is a valid-only pipeline. A slot carries an instruction
// when its valid bit is 1. There is no ready signal. The only backpressure is
// stall_out, which tells IF and IF/ID to hold their contents for that cycle.
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int INSTR_W    = 9,
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [INSTR_W-1:0]    if_instr,
    output logic [REG_ADDR_W-1:0] rf_raddr_a,
    output logic [REG_ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]     rf_rdata_a,
    input  logic [DATA_W-1:0]     rf_rdata_b,
    input  logic                  flush,
    input  logic                  ex_mem_regwrite,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    output logic                  stall_out,
    output logic                  id_ex_valid,
    output logic [7:0]            id_ex_ctrl,
    output logic [DATA_W-1:0]     id_ex_a,
    output logic [DATA_W-1:0]     id_ex_b,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [1:0]            id_ex_fwd_a,
    output logic [1:0]            id_ex_fwd_b,
    output logic [15:0]           stall_count
);

    // ------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_XOR = 3'd1,
        OP_SHL = 3'd2,
        OP_SHR = 3'd3,
        OP_ADD = 3'd4,
        OP_LW  = 3'd5,
        OP_SW  = 3'd6,
        OP_BR  = 3'd7
    } opcode_t;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic       memToReg;
        logic [2:0] op;
    } ControlSignals;

    // MEM means the producer is in ID/EX now, so it will be in EX/MEM when
    // this instruction executes. WB means the producer is in EX/MEM now.
    typedef enum logic [1:0] {
        FORWARD_NONE = 2'b00,
        FORWARD_WB   = 2'b01,
        FORWARD_MEM  = 2'b10
    } ForwardSel;

    typedef struct packed {
        logic                  valid;
        ControlSignals         ctrl;
        logic [DATA_W-1:0]     a;
        logic [DATA_W-1:0]     b;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rt;
        ForwardSel             fwdA;
        ForwardSel             fwdB;
    } IdExReg;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic ControlSignals decodeCtrl(input opcode_t op);
        ControlSignals c;
        c    = '0;
        c.op = op;
        case (op)
            OP_AND, OP_XOR, OP_SHL, OP_SHR, OP_ADD: begin
                c.regWrite = 1'b1;
            end
            OP_LW: begin
                c.regWrite = 1'b1;
                c.memRead  = 1'b1;
                c.memToReg = 1'b1;
            end
            OP_SW: c.memWrite = 1'b1;
            OP_BR: c.branch   = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // The ID/EX producer is checked first because it is younger than the
    // EX/MEM producer and therefore holds the newer value of the register.
    function automatic ForwardSel fwdSelect(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  memValid,
        input logic                  memRegWrite,
        input logic [REG_ADDR_W-1:0] memRd,
        input logic                  wbRegWrite,
        input logic [REG_ADDR_W-1:0] wbRd
    );
        if (memValid && memRegWrite && (memRd == src)) begin
            return FORWARD_MEM;
        end else if (wbRegWrite && (wbRd == src)) begin
            return FORWARD_WB;
        end
        return FORWARD_NONE;
    endfunction

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    opcode_t               opField;
    logic [REG_ADDR_W-1:0] rdField;
    logic [REG_ADDR_W-1:0] rtField;

    assign opField = opcode_t'(if_instr[INSTR_W-1 -: 3]);
    assign rdField = if_instr[2*REG_ADDR_W-1 : REG_ADDR_W];
    assign rtField = if_instr[REG_ADDR_W-1 : 0];

    assign rf_raddr_a = rdField;
    assign rf_raddr_b = rtField;

    // ------------------------------------------------------------------
    // Decode, hazard detection and next ID/EX content
    // ------------------------------------------------------------------
    IdExReg        idEx;
    IdExReg        idExNext;
    ControlSignals ctrlDec;
    ForwardSel     fwdA;
    ForwardSel     fwdB;
    logic          usesA;
    logic          srcHit;
    logic          stall;

    always_comb begin
        ctrlDec = decodeCtrl(opField);

        // For LW, rd names the destination rather than a source. Every
        // other opcode reads both rd and rt.
        usesA  = (opField != OP_LW);
        srcHit = (usesA && (rdField == idEx.rd)) || (rtField == idEx.rd);

        // A flush wins over the hazard. The slot is discarded anyway, so
        // holding IF would only waste a cycle.
        stall = idEx.valid && idEx.ctrl.memRead && if_valid && !flush && srcHit;

        // Unused sources still get a select. EX ignores it.
        fwdA = fwdSelect(rdField, idEx.valid, idEx.ctrl.regWrite, idEx.rd,
                         ex_mem_regwrite, ex_mem_rd);
        fwdB = fwdSelect(rtField, idEx.valid, idEx.ctrl.regWrite, idEx.rd,
                         ex_mem_regwrite, ex_mem_rd);

        // Start from a bubble: all zero, selects FORWARD_NONE.
        idExNext = '0;
        if (!flush && !stall && if_valid) begin
            idExNext.valid = 1'b1;
            idExNext.ctrl  = ctrlDec;
            idExNext.a     = rf_rdata_a;
            idExNext.b     = rf_rdata_b;
            idExNext.rd    = rdField;
            idExNext.rt    = rtField;
            idExNext.fwdA  = fwdA;
            idExNext.fwdB  = fwdB;
        end
    end

    assign stall_out = stall;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idEx <= '0;
        end else begin
            idEx <= idExNext;
        end
    end

    assign id_ex_valid = idEx.valid;
    assign id_ex_ctrl  = idEx.ctrl;
    assign id_ex_a     = idEx.a;
    assign id_ex_b     = idEx.b;
    assign id_ex_rd    = idEx.rd;
    assign id_ex_rt    = idEx.rt;
    assign id_ex_fwd_a = idEx.fwdA;
    assign id_ex_fwd_b = idEx.fwdB;

    // ------------------------------------------------------------------
    // Load-use bubble counter
    // ------------------------------------------------------------------
`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stallCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= 16'h0000;
        end else if (stall && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign stall_count = stallCnt;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Bench for decode_stage. Inputs change on the falling edge. stall_out is
// sampled 1 ns after the inputs change, and ID/EX is sampled 1 ns after the
// rising edge. Expected ID/EX words are pushed when a step is driven and
// popped when the DUT registers that step.
// Word layout: {valid, ctrl, a, b, rd, rt, fwd_a, fwd_b}.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    localparam int W = 35;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       if_valid = 1'b0;
    logic [8:0] if_instr = 9'h000;
    logic [2:0] rf_raddr_a, rf_raddr_b;
    logic [7:0] rf_rdata_a, rf_rdata_b;
    logic       flush = 1'b0;
    logic       ex_mem_regwrite = 1'b0;
    logic [2:0] ex_mem_rd = 3'd0;
    logic       stall_out;
    logic       id_ex_valid;
    logic [7:0] id_ex_ctrl;
    logic [7:0] id_ex_a, id_ex_b;
    logic [2:0] id_ex_rd, id_ex_rt;
    logic [1:0] id_ex_fwd_a, id_ex_fwd_b;
    logic [15:0] stall_count;

    logic [7:0]   rfm [8];
    logic [W-1:0] exp_q [$];
    int           tests_run = 0;
    int           tests_failed = 0;
    int           exp_cnt = 0;

    typedef struct {
        logic [8:0]   instr;
        logic         v;
        logic         fl;
        logic         rw;
        logic [2:0]   exrd;
        logic         stall;
        logic [W-1:0] exp;
    } step_t;

    always #5 clk = ~clk;

    // Register-file model with fixed contents during the run
    assign rf_rdata_a = rfm[rf_raddr_a];
    assign rf_rdata_b = rfm[rf_raddr_b];

    decode_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .rf_raddr_a      (rf_raddr_a),
        .rf_raddr_b      (rf_raddr_b),
        .rf_rdata_a      (rf_rdata_a),
        .rf_rdata_b      (rf_rdata_b),
        .flush           (flush),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_rd       (ex_mem_rd),
        .stall_out       (stall_out),
        .id_ex_valid     (id_ex_valid),
        .id_ex_ctrl      (id_ex_ctrl),
        .id_ex_a         (id_ex_a),
        .id_ex_b         (id_ex_b),
        .id_ex_rd        (id_ex_rd),
        .id_ex_rt        (id_ex_rt),
        .id_ex_fwd_a     (id_ex_fwd_a),
        .id_ex_fwd_b     (id_ex_fwd_b),
        .stall_count     (stall_count)
    );

    function automatic logic [W-1:0] pk(input logic v, input logic [7:0] c,
                                        input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] rd, input logic [2:0] rt,
                                        input logic [1:0] fa, input logic [1:0] fb);
        return {v, c, a, b, rd, rt, fa, fb};
    endfunction

    function automatic step_t mk(input logic [8:0] instr, input logic v, input logic fl,
                                 input logic rw, input logic [2:0] exrd, input logic stall,
                                 input logic [W-1:0] exp);
        step_t s;
        s.instr = instr; s.v = v; s.fl = fl; s.rw = rw; s.exrd = exrd;
        s.stall = stall; s.exp = exp;
        return s;
    endfunction

    function logic [W-1:0] idex_now();
        return {id_ex_valid, id_ex_ctrl, id_ex_a, id_ex_b, id_ex_rd, id_ex_rt,
                id_ex_fwd_a, id_ex_fwd_b};
    endfunction

    function automatic logic [15:0] cnt_exp(input int n);
`ifdef DECODE_STALL_CNT_EN
        return 16'(n);
`else
        return (n == -1) ? 16'h0001 : 16'h0000;
`endif
    endfunction

    // Driver: apply one IF/ID step on the falling edge and queue its result
    task automatic drive(input logic [8:0] instr, input logic v, input logic fl,
                         input logic rw, input logic [2:0] exrd, input logic [W-1:0] exp);
        @(negedge clk);
        if_instr = instr;
        if_valid = v;
        flush = fl;
        ex_mem_regwrite = rw;
        ex_mem_rd = exrd;
        exp_q.push_back(exp);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [W-1:0] e;
        if_instr = 9'h10A; if_valid = 1'b1; flush = 1'b0; ex_mem_regwrite = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (idex_now() !== '0) begin
            tests_failed++;
            $display("FAIL reset_idex: got %h want 0", idex_now());
        end
        tests_run++;
        if (stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall: got %b want 0", stall_out);
        end
        tests_run++;
        if (stall_count !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_count: got %h want 0000", stall_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(pk(1'b1, 8'h84, rfm[1], rfm[2], 3'd1, 3'd2, 2'b00, 2'b00));
        @(posedge clk);
        #1;
        tests_run++;
        e = exp_q.pop_front();
        if (idex_now() !== e) begin
            tests_failed++;
            $display("FAIL reset_release: got %h want %h", idex_now(), e);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_decode_sweep();
        step_t        s [$];
        logic [W-1:0] e;
        logic [7:0]   ctrl_tbl [8];
        ctrl_tbl = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'hCD, 8'h26, 8'h17};
        s.push_back(mk(9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0));
        for (int i = 0; i < 8; i++) begin
            logic [2:0] op, rd, rt;
            op = 3'(i); rd = 3'(i); rt = 3'(i + 4);
            s.push_back(mk({op, rd, rt}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                           pk(1'b1, ctrl_tbl[i], rfm[rd], rfm[rt], rd, rt, 2'b00, 2'b00)));
        end
        foreach (s[i]) begin
            drive(s[i].instr, s[i].v, s[i].fl, s[i].rw, s[i].exrd, s[i].exp);
            tests_run++;
            if (stall_out !== s[i].stall) begin
                tests_failed++;
                $display("FAIL sweep_stall[%0d]: got %b want %b", i, stall_out, s[i].stall);
            end
            @(posedge clk);
            #1;
            tests_run++;
            e = exp_q.pop_front();
            if (idex_now() !== e) begin
                tests_failed++;
                $display("FAIL sweep_idex[%0d]: got %h want %h", i, idex_now(), e);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random_alu();
        step_t        s [$];
        logic [W-1:0] e;
        for (int i = 0; i < 6; i++) begin
            logic [2:0] op, rd, rt;
            op = 3'($urandom_range(0, 4));
            rd = 3'($urandom_range(0, 7));
            rt = 3'($urandom_range(0, 7));
            s.push_back(mk(9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0));
            s.push_back(mk({op, rd, rt}, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                           pk(1'b1, {5'b10000, op}, rfm[rd], rfm[rt], rd, rt, 2'b00, 2'b00)));
        end
        foreach (s[i]) begin
            drive(s[i].instr, s[i].v, s[i].fl, s[i].rw, s[i].exrd, s[i].exp);
            tests_run++;
            if (stall_out !== s[i].stall) begin
                tests_failed++;
                $display("FAIL alu_stall[%0d]: got %b want %b", i, stall_out, s[i].stall);
            end
            @(posedge clk);
            #1;
            tests_run++;
            e = exp_q.pop_front();
            if (idex_now() !== e) begin
                tests_failed++;
                $display("FAIL alu_idex[%0d]: got %h want %h", i, idex_now(), e);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_use();
        step_t        s [$];
        logic [W-1:0] e;
        s.push_back(mk(9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0));
        s.push_back(mk(9'h159, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                       pk(1'b1, 8'hCD, rfm[3], rfm[1], 3'd3, 3'd1, 2'b00, 2'b00)));
        s.push_back(mk(9'h11C, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, '0));
        s.push_back(mk(9'h11C, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0,
                       pk(1'b1, 8'h84, rfm[3], rfm[4], 3'd3, 3'd4, 2'b01, 2'b00)));
        foreach (s[i]) begin
            drive(s[i].instr, s[i].v, s[i].fl, s[i].rw, s[i].exrd, s[i].exp);
            tests_run++;
            if (stall_out !== s[i].stall) begin
                tests_failed++;
                $display("FAIL loaduse_stall[%0d]: got %b want %b", i, stall_out, s[i].stall);
            end
            if (s[i].stall) exp_cnt++;
            @(posedge clk);
            #1;
            tests_run++;
            e = exp_q.pop_front();
            if (idex_now() !== e) begin
                tests_failed++;
                $display("FAIL loaduse_idex[%0d]: got %h want %h", i, idex_now(), e);
            end
        end
        tests_run++;
        if (stall_count !== cnt_exp(exp_cnt)) begin
            tests_failed++;
            $display("FAIL loaduse_count: got %h want %h", stall_count, cnt_exp(exp_cnt));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_forward_priority();
        step_t        s [$];
        logic [W-1:0] e;
        s.push_back(mk(9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0));
        s.push_back(mk(9'h10A, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                       pk(1'b1, 8'h84, rfm[1], rfm[2], 3'd1, 3'd2, 2'b00, 2'b00)));
        s.push_back(mk(9'h109, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0,
                       pk(1'b1, 8'h84, rfm[1], rfm[1], 3'd1, 3'd1, 2'b10, 2'b10)));
        s.push_back(mk(9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0));
        s.push_back(mk(9'h109, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0,
                       pk(1'b1, 8'h84, rfm[1], rfm[1], 3'd1, 3'd1, 2'b01, 2'b01)));
        s.push_back(mk(9'h18A, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                       pk(1'b1, 8'h26, rfm[1], rfm[2], 3'd1, 3'd2, 2'b10, 2'b00)));
        s.push_back(mk(9'h10A, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                       pk(1'b1, 8'h84, rfm[1], rfm[2], 3'd1, 3'd2, 2'b00, 2'b00)));
        s.push_back(mk(9'h10A, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0,
                       pk(1'b1, 8'h84, rfm[1], rfm[2], 3'd1, 3'd2, 2'b10, 2'b01)));
        foreach (s[i]) begin
            drive(s[i].instr, s[i].v, s[i].fl, s[i].rw, s[i].exrd, s[i].exp);
            tests_run++;
            if (stall_out !== s[i].stall) begin
                tests_failed++;
                $display("FAIL fwd_stall[%0d]: got %b want %b", i, stall_out, s[i].stall);
            end
            @(posedge clk);
            #1;
            tests_run++;
            e = exp_q.pop_front();
            if (idex_now() !== e) begin
                tests_failed++;
                $display("FAIL fwd_idex[%0d]: got %h want %h", i, idex_now(), e);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush_hazard();
        step_t        s [$];
        logic [W-1:0] e;
        s.push_back(mk(9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0));
        s.push_back(mk(9'h159, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                       pk(1'b1, 8'hCD, rfm[3], rfm[1], 3'd3, 3'd1, 2'b00, 2'b00)));
        s.push_back(mk(9'h11C, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, '0));
        s.push_back(mk(9'h11C, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                       pk(1'b1, 8'h84, rfm[3], rfm[4], 3'd3, 3'd4, 2'b00, 2'b00)));
        s.push_back(mk(9'h10A, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, '0));
        foreach (s[i]) begin
            drive(s[i].instr, s[i].v, s[i].fl, s[i].rw, s[i].exrd, s[i].exp);
            tests_run++;
            if (stall_out !== s[i].stall) begin
                tests_failed++;
                $display("FAIL flush_stall[%0d]: got %b want %b", i, stall_out, s[i].stall);
            end
            if (s[i].stall) exp_cnt++;
            @(posedge clk);
            #1;
            tests_run++;
            e = exp_q.pop_front();
            if (idex_now() !== e) begin
                tests_failed++;
                $display("FAIL flush_idex[%0d]: got %h want %h", i, idex_now(), e);
            end
        end
        tests_run++;
        if (stall_count !== cnt_exp(exp_cnt)) begin
            tests_failed++;
            $display("FAIL flush_count: got %h want %h", stall_count, cnt_exp(exp_cnt));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        step_t        s [$];
        logic [W-1:0] e;
        logic [W-1:0] lw33;
        lw33 = pk(1'b1, 8'hCD, rfm[3], rfm[3], 3'd3, 3'd3, 2'b01, 2'b01);
        s.push_back(mk(9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, '0));
        s.push_back(mk(9'h159, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0,
                       pk(1'b1, 8'hCD, rfm[3], rfm[1], 3'd3, 3'd1, 2'b00, 2'b00)));
        s.push_back(mk(9'h15B, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, '0));
        s.push_back(mk(9'h15B, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, lw33));
        s.push_back(mk(9'h15B, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, '0));
        s.push_back(mk(9'h15B, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, lw33));
        foreach (s[i]) begin
            drive(s[i].instr, s[i].v, s[i].fl, s[i].rw, s[i].exrd, s[i].exp);
            tests_run++;
            if (stall_out !== s[i].stall) begin
                tests_failed++;
                $display("FAIL b2b_stall[%0d]: got %b want %b", i, stall_out, s[i].stall);
            end
            if (s[i].stall) exp_cnt++;
            @(posedge clk);
            #1;
            tests_run++;
            e = exp_q.pop_front();
            if (idex_now() !== e) begin
                tests_failed++;
                $display("FAIL b2b_idex[%0d]: got %h want %h", i, idex_now(), e);
            end
        end
        tests_run++;
        if (stall_count !== cnt_exp(exp_cnt)) begin
            tests_failed++;
            $display("FAIL b2b_count: got %h want %h", stall_count, cnt_exp(exp_cnt));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_stall();
        logic [W-1:0] e;
        drive(9'h000, 1'b0, 1'b0, 1'b0, 3'd0, '0);
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        drive(9'h159, 1'b1, 1'b0, 1'b0, 3'd0, '0);
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        drive(9'h11C, 1'b1, 1'b0, 1'b0, 3'd0, '0);
        tests_run++;
        if (stall_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_stall_before: got %b want 1", stall_out);
        end
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        tests_run++;
        e = exp_q.pop_front();
        if (idex_now() !== e) begin
            tests_failed++;
            $display("FAIL midrst_idex: got %h want %h", idex_now(), e);
        end
        tests_run++;
        if (stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_stall_during: got %b want 0", stall_out);
        end
        if_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(9'h11C, 1'b1, 1'b0, 1'b0, 3'd0,
              pk(1'b1, 8'h84, rfm[3], rfm[4], 3'd3, 3'd4, 2'b00, 2'b00));
        tests_run++;
        if (stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_stall_after: got %b want 0", stall_out);
        end
        @(posedge clk);
        #1;
        tests_run++;
        e = exp_q.pop_front();
        if (idex_now() !== e) begin
            tests_failed++;
            $display("FAIL midrst_decode: got %h want %h", idex_now(), e);
        end
        tests_run++;
        if (stall_count !== cnt_exp(exp_cnt)) begin
            tests_failed++;
            $display("FAIL midrst_count: got %h want %h", stall_count, cnt_exp(exp_cnt));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturation();
        logic [15:0] want;
`ifdef DECODE_STALL_CNT_EN
        @(negedge clk);
        force dut.stallCnt = 16'hFFFE;
        #1;
        release dut.stallCnt;
        want = 16'hFFFF;
`else
        want = 16'h0000;
`endif
        for (int k = 0; k < 3; k++) begin
            drive(9'h159, 1'b1, 1'b0, 1'b0, 3'd0, '0);
            @(posedge clk); #1;
            void'(exp_q.pop_front());
            drive(9'h11C, 1'b1, 1'b0, 1'b0, 3'd0, '0);
            tests_run++;
            if (stall_out !== 1'b1) begin
                tests_failed++;
                $display("FAIL sat_stall[%0d]: got %b want 1", k, stall_out);
            end
            @(posedge clk); #1;
            void'(exp_q.pop_front());
            tests_run++;
            if (stall_count !== want) begin
                tests_failed++;
                $display("FAIL sat_count[%0d]: got %h want %h", k, stall_count, want);
            end
            drive(9'h000, 1'b0, 1'b0, 1'b0, 3'd0, '0);
            @(posedge clk); #1;
            void'(exp_q.pop_front());
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) rfm[i] = 8'($urandom_range(0, 255));
        test_reset();
        test_decode_sweep();
        test_random_alu();
        test_load_use();
        test_forward_priority();
        test_flush_hazard();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturation();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
